// File: rtl/cv32e40s_fencei_sequencer_if.sv
// fence.i flush handshake bundle between controller/cache environment and the sequencer.
interface cv32e40s_fencei_sequencer_if #(
    parameter int LAT_WIDTH = 16
);
    logic                 fencei_start_i;
    logic                 lsu_busy_i;
    logic                 fencei_flush_ack_i;
    logic                 fencei_flush_req_o;
    logic                 fencei_done_o;
    logic                 busy_o;
    logic                 timeout_err_o;
    logic [LAT_WIDTH-1:0] latency_o;

    modport master (
        output fencei_start_i, lsu_busy_i, fencei_flush_ack_i,
        input  fencei_flush_req_o, fencei_done_o, busy_o, timeout_err_o, latency_o
    );

    modport slave (
        input  fencei_start_i, lsu_busy_i, fencei_flush_ack_i,
        output fencei_flush_req_o, fencei_done_o, busy_o, timeout_err_o, latency_o
    );
endinterface

// File: rtl/cv32e40s_fencei_sequencer.sv
// fence.i sequencer: drain LSU, run the flush req/ack handshake, pulse done, report latency/timeout.
module cv32e40s_fencei_sequencer #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int LAT_WIDTH      = 16
) (
    input logic clk,
    input logic rst_n,
    cv32e40s_fencei_sequencer_if.slave bus
);
    localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, REQ, DONE} state_e;

    state_e               state, state_nxt;
    logic [LAT_WIDTH-1:0] lat_cnt, latency;
    logic [TW-1:0]        tmo_cnt;
    logic                 timeout_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.fencei_start_i) state_nxt = bus.lsu_busy_i ? DRAIN : REQ;
            DRAIN: if (!bus.lsu_busy_i) state_nxt = REQ;
            REQ:   if (bus.fencei_flush_ack_i) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt     <= '0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
            latency     <= '0;
        end else if (state == IDLE) begin
            if (bus.fencei_start_i) begin
                lat_cnt     <= '0;
                tmo_cnt     <= '0;
                timeout_err <= 1'b0;
            end
        end else begin
            if (lat_cnt != '1) lat_cnt <= lat_cnt + 1'b1;
            if (state == REQ && !bus.fencei_flush_ack_i) begin
                if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
                if (TIMEOUT_CYCLES != 0 && tmo_cnt == TMO_LAST) timeout_err <= 1'b1;
            end
            // DONE cycle itself is included in the reported latency
            if (state == DONE) latency <= (lat_cnt == '1) ? lat_cnt : lat_cnt + 1'b1;
        end
    end

    assign bus.fencei_flush_req_o = (state == REQ);
    assign bus.fencei_done_o      = (state == DONE);
    assign bus.busy_o             = (state != IDLE);
    assign bus.timeout_err_o      = timeout_err;
    assign bus.latency_o          = latency;

    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        bus.fencei_flush_req_o && !bus.fencei_flush_ack_i |=> bus.fencei_flush_req_o);
    a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        bus.fencei_done_o |=> !bus.fencei_done_o);
    a_done_after_ack: assert property (@(posedge clk) disable iff (!rst_n)
        bus.fencei_done_o |-> $past(bus.fencei_flush_req_o && bus.fencei_flush_ack_i));
    a_req_needs_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !bus.busy_o |-> !bus.fencei_flush_req_o);
    a_start_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.fencei_start_i && bus.busy_o))
        else $warning("fencei_start_i while sequencer busy; ignored");
    a_ack_without_req: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.fencei_flush_ack_i && !bus.fencei_flush_req_o))
        else $warning("fencei_flush_ack_i without request; ignored");
endmodule
